rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
Shares the single register-file write port between two writeback sources. The primary source is the in-order pipeline WB stage, which has no backpressure. The secondary source is a long-latency unit (mult/div, late loads) using a valid/ready handshake. Secondary writes are buffered in a small in-order queue and drain into the register file whenever the primary is idle. The block sits between the WB stage / long-latency unit and the register-file write port, and supplies stall and forwarding information to the pipeline control.

Parameters:
RF_ADDR_WIDTH, 5, register address bits
RF_DATA_WIDTH, 32, data bits per register
SQ_DEPTH, 4, secondary queue entries (power of 2, >=2)
STARVE_LIMIT, 8, cycles a non-empty queue may go without a pop before a stall is requested

Ports:
clk  in  1  clock
n_reset  in  1  reset, asynchronous, active-low
p_wr_en  in  1  primary write request
p_w_addr  in  RF_ADDR_WIDTH  primary destination register
p_w_data  in  RF_DATA_WIDTH  primary write data
s_valid  in  1  secondary write request
s_ready  out  1  secondary accept; equals !sq_full
s_w_addr  in  RF_ADDR_WIDTH  secondary destination register
s_w_data  in  RF_DATA_WIDTH  secondary write data
rf_wr_en  out  1  register-file write enable (registered)
rf_w_addr  out  RF_ADDR_WIDTH  register-file write address (registered)
rf_w_data  out  RF_DATA_WIDTH  register-file write data (registered)
stall_req  out  1  request pipeline bubble (registered)
sq_count  out  log2(SQ_DEPTH)+1  queue occupancy
q_addr  in  RF_ADDR_WIDTH  forwarding lookup address
q_hit  out  1  q_addr matches a queued entry (combinational)
q_data  out  RF_DATA_WIDTH  data of the newest matching queued entry; 0 if no hit

Behaviour:
- Reset (async): queue emptied, read/write pointers and starvation counter = 0. rf_wr_en=0, rf_w_addr=0, rf_w_data=0, stall_req=0, sq_count=0, s_ready=1. Reset mid-operation discards all queued writes.
- Accept: s_acc = s_valid && s_ready. s_ready depends only on state, never on s_valid.
- Per-cycle arbitration, evaluated in priority order:
  1. p_wr_en=1: the primary write is registered to the rf_* outputs. It is never dropped, even if stall_req=1 (protocol violation, still served).
  2. Else, queue non-empty: the queue head is popped and registered to the rf_* outputs.
  3. Else, queue empty and s_acc: cut-through. The secondary write goes directly to the rf_* outputs and the queue is unchanged.
  4. Else: rf_wr_en=0 next cycle. rf_w_addr and rf_w_data hold their previous values.
- Latency: exactly 1 cycle from a served request to rf_wr_en=1.
- Queue:
  - s_acc not consumed by cut-through pushes at the tail.
  - Push and pop in the same cycle: sq_count unchanged. This is legal when full (pop frees an entry; s_ready is still 0 that cycle, so no push occurs).
  - Pointers wrap modulo SQ_DEPTH.
  - Drain is strictly FIFO. Secondary writes reach the register file in acceptance order.
- Ordering vs primary: there is no WAW check between sources. Issue logic guarantees the primary and queued secondary writes never target the same register out of order.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, each cycle the queue is non-empty and no pop occurs.
  - Clears on any pop or when the queue is empty.
  - stall_req (registered) = next-state (count == SQ_DEPTH) || (starve_cnt >= STARVE_LIMIT).
  - The pipeline holds p_wr_en=0 in every cycle stall_req=1. Pops then proceed, and stall_req deasserts the cycle after the condition clears.
- Forwarding: q_hit/q_data search all occupied queue entries. The newest match (closest to tail) wins. Entries being popped this cycle are still searched. The rf_* output stage is not searched.

Optional Feature:
Macro RF_WB_ZERO_FILTER_EN.
- Defined: writes to register 0 are discarded from both sources.
  - Primary: behaves as p_wr_en=0.
  - Secondary: accepted (handshake completes) but neither queued nor written.
  - q_addr=0 always gives q_hit=0.
- Undefined: address 0 is treated like any other register.

Test Plan:
- Reset: assert n_reset=0 mid-drain with sq_count=3 -> all outputs 0 immediately; sq_count=0 and s_ready=1 after release.
- Cut-through: queue empty, p_wr_en=0, s_valid=1, s_w_addr=7, s_w_data=0xDEADBEEF -> next cycle rf_wr_en=1, rf_w_addr=7, rf_w_data=0xDEADBEEF; sq_count stays 0.
- Primary priority: p_wr_en=1 continuously with addresses 1..6; secondary pushes 3,4,5,6 (data 0x30..0x60) -> rf outputs follow primary only; sq_count reaches 4, s_ready=0, stall_req=1.
- Drain and starvation: continue the previous case with p_wr_en held high -> stall_req stays 1. Drop p_wr_en to 0 -> rf writes to 3,4,5,6 in order over 4 cycles, then stall_req=0. Separately, hold primary busy with 1 queued entry for 8 cycles -> stall_req=1 in cycle 9.
- Forwarding: queue holds (5,0x11), (9,0x22), (5,0x33); q_addr=5 -> q_hit=1, q_data=0x33. q_addr=2 -> q_hit=0, q_data=0.
- Zero filter: with RF_WB_ZERO_FILTER_EN defined, p_wr_en=1 with p_w_addr=0 and queue non-empty -> head is popped that cycle and no write to 0 occurs. Without the macro -> rf_wr_en=1 with rf_w_addr=0.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: writeback sources, register-file port and
// forwarding lookup bundled for rf_wb_arbiter.
interface rf_wb_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32,
  parameter int CW = 3
);
  logic          p_wr_en;
  logic [AW-1:0] p_w_addr;
  logic [DW-1:0] p_w_data;
  logic          s_valid;
  logic          s_ready;
  logic [AW-1:0] s_w_addr;
  logic [DW-1:0] s_w_data;
  logic          rf_wr_en;
  logic [AW-1:0] rf_w_addr;
  logic [DW-1:0] rf_w_data;
  logic          stall_req;
  logic [CW-1:0] sq_count;
  logic [AW-1:0] q_addr;
  logic          q_hit;
  logic [DW-1:0] q_data;

  modport slave (
    input  p_wr_en, p_w_addr, p_w_data,
    input  s_valid, s_w_addr, s_w_data,
    input  q_addr,
    output s_ready,
    output rf_wr_en, rf_w_addr, rf_w_data,
    output stall_req, sq_count,
    output q_hit, q_data
  );

  modport master (
    output p_wr_en, p_w_addr, p_w_data,
    output s_valid, s_w_addr, s_w_data,
    output q_addr,
    input  s_ready,
    input  rf_wr_en, rf_w_addr, rf_w_data,
    input  stall_req, sq_count,
    input  q_hit, q_data
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the RF write port between WB and a queued
// long-latency source. Option macro: RF_WB_ZERO_FILTER_EN.
module rf_wb_arbiter #(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int RF_DATA_WIDTH = 32,
  parameter int SQ_DEPTH      = 4,
  parameter int STARVE_LIMIT  = 8
) (
  input logic           clk,
  input logic           n_reset,
  rf_wb_arbiter_if.slave bus
);
  localparam int AW = RF_ADDR_WIDTH;
  localparam int DW = RF_DATA_WIDTH;
  localparam int PW = $clog2(SQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(SQ_DEPTH);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  logic [AW-1:0] addr_mem [SQ_DEPTH];
  logic [DW-1:0] data_mem [SQ_DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          rf_en_q, rf_en_d;
  logic [AW-1:0] rf_addr_q, rf_addr_d;
  logic [DW-1:0] rf_data_q, rf_data_d;
  logic          stall_q, stall_d;

  logic full, empty, s_rdy, s_acc;
  logic p_en, s_keep;
  logic pop, cut, push;
  logic          hit;
  logic [DW-1:0] hit_data;
  logic [PW-1:0] idx;

  always_comb begin
    full  = (count_q == DEPTH_C);
    empty = (count_q == '0);
    s_rdy = !full;
    s_acc = bus.s_valid && s_rdy;
`ifdef RF_WB_ZERO_FILTER_EN
    p_en   = bus.p_wr_en && (bus.p_w_addr != '0);
    s_keep = s_acc && (bus.s_w_addr != '0);
`else
    p_en   = bus.p_wr_en;
    s_keep = s_acc;
`endif
    pop  = !p_en && !empty;
    cut  = !p_en && empty && s_keep;
    push = s_keep && !cut;
  end

  always_comb begin
    rf_en_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    unique case (1'b1)
      p_en: begin
        rf_en_d   = 1'b1;
        rf_addr_d = bus.p_w_addr;
        rf_data_d = bus.p_w_data;
      end
      pop: begin
        rf_en_d   = 1'b1;
        rf_addr_d = addr_mem[rd_ptr_q];
        rf_data_d = data_mem[rd_ptr_q];
      end
      cut: begin
        rf_en_d   = 1'b1;
        rf_addr_d = bus.s_w_addr;
        rf_data_d = bus.s_w_data;
      end
      default: rf_en_d = 1'b0;
    endcase
  end

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (pop || empty)
      starve_d = '0;
    else if (starve_q == SLIM)
      starve_d = starve_q;
    else
      starve_d = starve_q + SW'(1);
    stall_d = (count_d == DEPTH_C) || (starve_d >= SLIM);
  end

  // later (newer) entries override earlier matches
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = rd_ptr_q;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q && addr_mem[idx] == bus.q_addr) begin
        hit      = 1'b1;
        hit_data = data_mem[idx];
      end
    end
`ifdef RF_WB_ZERO_FILTER_EN
    if (bus.q_addr == '0) begin
      hit      = 1'b0;
      hit_data = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= bus.s_w_addr;
      data_mem[wr_ptr_q] <= bus.s_w_data;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      rf_en_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      stall_q   <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      rf_en_q   <= rf_en_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      stall_q   <= stall_d;
    end
  end

  assign bus.s_ready   = s_rdy;
  assign bus.rf_wr_en  = rf_en_q;
  assign bus.rf_w_addr = rf_addr_q;
  assign bus.rf_w_data = rf_data_q;
  assign bus.stall_req = stall_q;
  assign bus.sq_count  = count_q;
  assign bus.q_hit     = hit;
  assign bus.q_data    = hit_data;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed stimulus, queue-based reference model
// checked every cycle, plus literal expectations per scenario.
module tb_rf_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic n_reset;
  int   checks = 0;
  int   errors = 0;

  rf_wb_arbiter_if #(.AW(5), .DW(32), .CW(3)) bus ();

  rf_wb_arbiter #(
    .RF_ADDR_WIDTH(5),
    .RF_DATA_WIDTH(32),
    .SQ_DEPTH(DEPTH),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic        m_en = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic        m_stall = 1'b0;
  int          m_starve = 0;
  int          sz0;
  bit          pe, keep, popped;
  ent_t        h;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask

  // reference model: FIFO of pending secondary writes
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mq.delete();
      m_en = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_stall = 1'b0;
      m_starve = 0;
    end else begin
      sz0 = mq.size();
      pe = bus.p_wr_en;
      keep = bus.s_valid && (sz0 < DEPTH);
`ifdef RF_WB_ZERO_FILTER_EN
      pe = pe && (bus.p_w_addr != 5'd0);
      keep = keep && (bus.s_w_addr != 5'd0);
`endif
      popped = 1'b0;
      if (pe) begin
        m_en = 1'b1;
        m_addr = bus.p_w_addr;
        m_data = bus.p_w_data;
      end else if (sz0 > 0) begin
        h = mq.pop_front();
        m_en = 1'b1;
        m_addr = h.a;
        m_data = h.d;
        popped = 1'b1;
      end else if (keep) begin
        m_en = 1'b1;
        m_addr = bus.s_w_addr;
        m_data = bus.s_w_data;
        keep = 1'b0;
      end else begin
        m_en = 1'b0;
      end
      if (keep) mq.push_back({bus.s_w_addr, bus.s_w_data});
      if (popped || sz0 == 0) m_starve = 0;
      else if (m_starve < LIMIT) m_starve++;
      m_stall = (mq.size() == DEPTH) || (m_starve >= LIMIT);
    end
  end

  always @(negedge clk) begin
    logic        e_hit;
    logic [31:0] e_data;
    e_hit = 1'b0;
    e_data = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!e_hit && mq[i].a == bus.q_addr) begin
        e_hit = 1'b1;
        e_data = mq[i].d;
      end
    end
`ifdef RF_WB_ZERO_FILTER_EN
    if (bus.q_addr == 5'd0) begin
      e_hit = 1'b0;
      e_data = '0;
    end
`endif
    chk("rf_wr_en", 64'(bus.rf_wr_en), 64'(m_en));
    chk("rf_w_addr", 64'(bus.rf_w_addr), 64'(m_addr));
    chk("rf_w_data", 64'(bus.rf_w_data), 64'(m_data));
    chk("stall_req", 64'(bus.stall_req), 64'(m_stall));
    chk("sq_count", 64'(bus.sq_count), 64'(mq.size()));
    chk("s_ready", 64'(bus.s_ready), 64'(mq.size() < DEPTH));
    chk("q_hit", 64'(bus.q_hit), 64'(e_hit));
    chk("q_data", 64'(bus.q_data), 64'(e_data));
  end

  task automatic cyc(input logic pe_i, input logic [4:0] pa,
                     input logic [31:0] pd, input logic sv,
                     input logic [4:0] sa, input logic [31:0] sd);
    bus.p_wr_en = pe_i;
    bus.p_w_addr = pa;
    bus.p_w_data = pd;
    bus.s_valid = sv;
    bus.s_w_addr = sa;
    bus.s_w_data = sd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    n_reset = 1'b1;
    bus.p_wr_en = 1'b0;
    bus.p_w_addr = '0;
    bus.p_w_data = '0;
    bus.s_valid = 1'b0;
    bus.s_w_addr = '0;
    bus.s_w_data = '0;
    bus.q_addr = 5'd2;
    #1 n_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 64'(bus.rf_wr_en), 64'd0);
    chk("rst_count", 64'(bus.sq_count), 64'd0);
    chk("rst_ready", 64'(bus.s_ready), 64'd1);
    chk("rst_stall", 64'(bus.stall_req), 64'd0);
    n_reset = 1'b1;

    // cut-through
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEADBEEF);
    chk("ct_en", 64'(bus.rf_wr_en), 64'd1);
    chk("ct_addr", 64'(bus.rf_w_addr), 64'd7);
    chk("ct_data", 64'(bus.rf_w_data), 64'hDEADBEEF);
    chk("ct_count", 64'(bus.sq_count), 64'd0);
    idle();
    chk("hold_en", 64'(bus.rf_wr_en), 64'd0);
    chk("hold_addr", 64'(bus.rf_w_addr), 64'd7);

    // primary priority while secondary fills the queue
    for (int i = 1; i <= 6; i++)
      cyc(1'b1, 5'(i), 32'h100 + 32'(i), i <= 4,
          5'(i + 2), 32'((i + 2) * 16));
    chk("pp_count", 64'(bus.sq_count), 64'd4);
    chk("pp_ready", 64'(bus.s_ready), 64'd0);
    chk("pp_stall", 64'(bus.stall_req), 64'd1);
    chk("pp_addr", 64'(bus.rf_w_addr), 64'd6);
    chk("pp_data", 64'(bus.rf_w_data), 64'h106);
    repeat (2) cyc(1'b1, 5'd1, 32'h1, 1'b1, 5'd8, 32'h80);
    chk("full_stall", 64'(bus.stall_req), 64'd1);
    chk("full_count", 64'(bus.sq_count), 64'd4);
    for (int k = 0; k < 4; k++) begin
      idle();
      chk("drain_addr", 64'(bus.rf_w_addr), 64'(3 + k));
      chk("drain_data", 64'(bus.rf_w_data), 64'((3 + k) * 16));
    end
    chk("drain_count", 64'(bus.sq_count), 64'd0);
    chk("drain_stall", 64'(bus.stall_req), 64'd0);

    // starvation with one queued entry
    cyc(1'b1, 5'd1, 32'h2, 1'b1, 5'd10, 32'hA);
    for (int j = 1; j <= 8; j++) begin
      cyc(1'b1, 5'd2, 32'(j), 1'b0, 5'd0, 32'd0);
      if (j == 7) chk("starve7", 64'(bus.stall_req), 64'd0);
      if (j == 8) chk("starve8", 64'(bus.stall_req), 64'd1);
    end
    idle();
    chk("starve_pop", 64'(bus.rf_w_addr), 64'd10);
    chk("starve_clr", 64'(bus.stall_req), 64'd0);

    // forwarding: newest match wins
    cyc(1'b1, 5'd1, 32'h0, 1'b1, 5'd5, 32'h11);
    cyc(1'b1, 5'd1, 32'h0, 1'b1, 5'd9, 32'h22);
    cyc(1'b1, 5'd1, 32'h0, 1'b1, 5'd5, 32'h33);
    chk("fw_count", 64'(bus.sq_count), 64'd3);
    bus.q_addr = 5'd5;
    #1;
    chk("fw5_hit", 64'(bus.q_hit), 64'd1);
    chk("fw5_data", 64'(bus.q_data), 64'h33);
    bus.q_addr = 5'd9;
    #1;
    chk("fw9_data", 64'(bus.q_data), 64'h22);
    bus.q_addr = 5'd2;
    #1;
    chk("fw2_hit", 64'(bus.q_hit), 64'd0);
    chk("fw2_data", 64'(bus.q_data), 64'd0);
    bus.q_addr = 5'd5;
    repeat (3) idle();

    // write to register 0 with queue non-empty
    cyc(1'b1, 5'd1, 32'h1, 1'b1, 5'd4, 32'h44);
    bus.q_addr = 5'd0;
    cyc(1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'd0);
    chk("z_en", 64'(bus.rf_wr_en), 64'd1);
`ifdef RF_WB_ZERO_FILTER_EN
    chk("z_addr", 64'(bus.rf_w_addr), 64'd4);
    chk("z_data", 64'(bus.rf_w_data), 64'h44);
    chk("z_count", 64'(bus.sq_count), 64'd0);
`else
    chk("z_addr", 64'(bus.rf_w_addr), 64'd0);
    chk("z_data", 64'(bus.rf_w_data), 64'h99);
    chk("z_count", 64'(bus.sq_count), 64'd1);
`endif
    idle();

    // reset mid-drain
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 5'd1, 32'h5, 1'b1, 5'(11 + i), 32'(i));
    idle();
    chk("md_count", 64'(bus.sq_count), 64'd3);
    #1 n_reset = 1'b0;
    #1;
    chk("mr_en", 64'(bus.rf_wr_en), 64'd0);
    chk("mr_addr", 64'(bus.rf_w_addr), 64'd0);
    chk("mr_data", 64'(bus.rf_w_data), 64'd0);
    chk("mr_stall", 64'(bus.stall_req), 64'd0);
    chk("mr_count", 64'(bus.sq_count), 64'd0);
    @(posedge clk);
    #1 n_reset = 1'b1;
    idle();
    chk("post_count", 64'(bus.sq_count), 64'd0);
    chk("post_ready", 64'(bus.s_ready), 64'd1);
    chk("post_en", 64'(bus.rf_wr_en), 64'd0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
